// File: rtl/text_vram_axil_slave_if.sv
// AXI4-Lite bundle between a bus master and the text VRAM responder.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R); clock and reset
// stay outside the interface as plain module ports.
// Modports: master drives addresses, write data and response readies;
// slave drives the channel readies, write response and read data.
interface text_vram_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/text_vram_axil_slave.sv
// Character/attribute word store of the HDMI text controller.
// AXI4-Lite slave on one side, read-only registered video port on the other.
// Write and read channels are independent FSMs.
//
// Ports:
//   ACLK      - single clock
//   ARESETN   - asynchronous active-low reset (clears FSMs, outputs, words)
//   s_axi     - AXI4-Lite slave (text_vram_axil_slave_if.slave)
//   vid_addr  - video-side word index
//   vid_data  - video-side word, one-cycle latency, 0 when out of range
//
// Build option: TEXT_VRAM_WRCOUNT_EN maps word index NUM_WORDS to a
// read-only counter of committed OKAY writes.
//
// Write FSM
//   state     | meaning
//   WR_IDLE   | AW and W both accepted
//   WR_WAIT_W | address latched, waiting for write data
//   WR_WAIT_A | data/strobes latched, waiting for address
//   WR_RESP   | word committed, BVALID held until BREADY
// Read FSM
//   state     | meaning
//   RD_IDLE   | AR accepted
//   RD_DATA   | RDATA/RRESP held until RREADY
module text_vram_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int NUM_WORDS          = 601
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  text_vram_axil_slave_if.slave         s_axi,
  input  logic [C_S_AXI_ADDR_WIDTH-3:0] vid_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] vid_data
);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] NUM_IDX = IDX_W'(NUM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic [DW-1:0]    mem [NUM_WORDS];
  logic             run;
  logic [IDX_W-1:0] aw_idx_q;
  logic [DW-1:0]    wdata_q;
  logic [SW-1:0]    wstrb_q;
  logic [1:0]       bresp_q;
  logic [DW-1:0]    rdata_q;
  logic [1:0]       rresp_q;

  logic             awready, wready, arready;
  logic             commit, latch_aw, latch_w, rd_start;
  logic [IDX_W-1:0] cm_idx;
  logic [DW-1:0]    cm_data;
  logic [SW-1:0]    cm_strb;
  logic             cm_ok;
  logic [DW-1:0]    rd_word, vid_word;
  logic [1:0]       rd_resp;

  wire [IDX_W-1:0] aw_idx = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  wire [IDX_W-1:0] ar_idx = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

`ifdef TEXT_VRAM_WRCOUNT_EN
  logic [DW-1:0] wr_cnt;
`endif

  // Holds every READY low while reset is asserted and for the first cycle after.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) run <= 1'b0;
    else          run <= 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // Commit source depends on which half arrived last: bus values for the
  // half handshaking now, latched values for the half that came earlier.
  always_comb begin
    wr_next  = wr_state;
    awready  = 1'b0;
    wready   = 1'b0;
    commit   = 1'b0;
    latch_aw = 1'b0;
    latch_w  = 1'b0;
    cm_idx   = aw_idx_q;
    cm_data  = wdata_q;
    cm_strb  = wstrb_q;
    case (wr_state)
      WR_IDLE: begin
        awready = run;
        wready  = run;
        if (run && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
          commit  = 1'b1;
          cm_idx  = aw_idx;
          cm_data = s_axi.S_AXI_WDATA;
          cm_strb = s_axi.S_AXI_WSTRB;
          wr_next = WR_RESP;
        end else if (run && s_axi.S_AXI_AWVALID) begin
          latch_aw = 1'b1;
          wr_next  = WR_WAIT_W;
        end else if (run && s_axi.S_AXI_WVALID) begin
          latch_w = 1'b1;
          wr_next = WR_WAIT_A;
        end
      end
      WR_WAIT_W: begin
        wready = run;
        if (run && s_axi.S_AXI_WVALID) begin
          commit  = 1'b1;
          cm_data = s_axi.S_AXI_WDATA;
          cm_strb = s_axi.S_AXI_WSTRB;
          wr_next = WR_RESP;
        end
      end
      WR_WAIT_A: begin
        awready = run;
        if (run && s_axi.S_AXI_AWVALID) begin
          commit  = 1'b1;
          cm_idx  = aw_idx;
          wr_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next  = rd_state;
    arready  = 1'b0;
    rd_start = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready = run;
        if (run && s_axi.S_AXI_ARVALID) begin
          rd_start = 1'b1;
          rd_next  = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign cm_ok = (cm_idx < NUM_IDX);

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    if (ar_idx < NUM_IDX) begin
      rd_word = mem[ar_idx];
      rd_resp = RESP_OKAY;
    end
`ifdef TEXT_VRAM_WRCOUNT_EN
    else if (ar_idx == NUM_IDX) begin
      rd_word = wr_cnt;
      rd_resp = RESP_OKAY;
    end
`endif
  end

  always_comb begin
    vid_word = '0;
    if (vid_addr < NUM_IDX) vid_word = mem[vid_addr];
  end

  // All reads use the pre-edge array contents, so a read landing on the
  // same edge as a commit to that word returns the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      vid_data <= '0;
    end else begin
      if (latch_aw) aw_idx_q <= aw_idx;
      if (latch_w) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        bresp_q <= cm_ok ? RESP_OKAY : RESP_SLVERR;
        if (cm_ok) begin
          for (int b = 0; b < SW; b++)
            if (cm_strb[b]) mem[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
        end
      end
      if (rd_start) begin
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
      end
      vid_data <= vid_word;
    end
  end

`ifdef TEXT_VRAM_WRCOUNT_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)             wr_cnt <= '0;
    else if (commit && cm_ok) wr_cnt <= wr_cnt + 1'b1;
  end
`endif

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = (wr_state == WR_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = (rd_state == RD_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
endmodule

// File: tb/tb_text_vram_axil_slave.sv
module tb_text_vram_axil_slave;
  localparam int LIMIT = 20;

  logic        clk_sys;
  logic        rst_n;
  logic [9:0]  vid_addr;
  logic [31:0] vid_data;
  int          checks;
  int          errors;
  int          ok_cnt;
  logic [31:0] rd_d;
  logic [1:0]  rd_r;
  logic [1:0]  wr_r;

  text_vram_axil_slave_if bus ();

  text_vram_axil_slave dut (
    .ACLK     (clk_sys),
    .ARESETN  (rst_n),
    .s_axi    (bus.slave),
    .vid_addr (vid_addr),
    .vid_data (vid_data)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    @(negedge clk_sys);
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_WVALID  = 1'b1;
    n = 0;
    while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < LIMIT) begin
      @(negedge clk_sys);
      n++;
    end
    if (n == LIMIT) check_val("wr_ready_timeout", 32'd0, 32'd1);
    @(posedge clk_sys);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < LIMIT) begin
      @(negedge clk_sys);
      n++;
    end
    if (n == LIMIT) check_val("bvalid_timeout", 32'd0, 32'd1);
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge clk_sys);
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < LIMIT) begin
      @(negedge clk_sys);
      n++;
    end
    if (n == LIMIT) check_val("ar_ready_timeout", 32'd0, 32'd1);
    @(posedge clk_sys);
    #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < LIMIT) begin
      @(negedge clk_sys);
      n++;
    end
    if (n == LIMIT) check_val("rvalid_timeout", 32'd0, 32'd1);
    d    = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ok_cnt = 0;
    rst_n  = 1'b0;
    vid_addr = '0;
    bus.S_AXI_AWADDR = '0;  bus.S_AXI_AWPROT = '0;  bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0;  bus.S_AXI_WSTRB  = '0;  bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0;  bus.S_AXI_ARPROT = '0;  bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // reset state
    #23;
    check_val("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    check_val("rst_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    check_val("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    check_val("rst_bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd0);
    check_val("rst_rvalid",  {31'd0, bus.S_AXI_RVALID},  32'd0);
    check_val("rst_vid",     vid_data, 32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    @(posedge clk_sys);
    #1;
    check_val("run_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);

    // simultaneous AW/W writes then readback
    for (int i = 0; i < 4; i++) begin
      axi_write(12'(4 * i), 32'(i + 1), 4'hF, wr_r);
      check_val("w4_bresp", {30'd0, wr_r}, 32'd0);
      ok_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(12'(4 * i), rd_d, rd_r);
      check_val("r4_data", rd_d, 32'(i + 1));
      check_val("r4_rresp", {30'd0, rd_r}, 32'd0);
    end

    // AW three cycles ahead of W
    @(negedge clk_sys);
    bus.S_AXI_AWADDR = 12'h010;
    bus.S_AXI_AWVALID = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    check_val("awfirst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    check_val("awfirst_wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
    repeat (2) @(posedge clk_sys);
    #1;
    check_val("awfirst_bvalid_wait", {31'd0, bus.S_AXI_BVALID}, 32'd0);
    bus.S_AXI_WDATA = 32'h0000_00AA;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_WVALID = 1'b0;
    check_val("awfirst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    check_val("awfirst_bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    ok_cnt++;

    // W three cycles ahead of AW
    @(negedge clk_sys);
    bus.S_AXI_WDATA = 32'h0000_00BB;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_WVALID = 1'b0;
    check_val("wfirst_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    check_val("wfirst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    repeat (2) @(posedge clk_sys);
    #1;
    check_val("wfirst_wready_wait", {31'd0, bus.S_AXI_WREADY}, 32'd0);
    bus.S_AXI_AWADDR = 12'h018;
    bus.S_AXI_AWVALID = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    check_val("wfirst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    ok_cnt++;
    axi_read(12'h010, rd_d, rd_r);
    check_val("awfirst_rdata", rd_d, 32'h0000_00AA);
    axi_read(12'h018, rd_d, rd_r);
    check_val("wfirst_rdata", rd_d, 32'h0000_00BB);

    // byte strobes on word 5, then video port
    axi_write(12'h014, 32'h1122_3344, 4'hF, wr_r);
    axi_write(12'h014, 32'hAABB_CCDD, 4'b0010, wr_r);
    ok_cnt += 2;
    check_val("strb_bresp", {30'd0, wr_r}, 32'd0);
    axi_read(12'h014, rd_d, rd_r);
    check_val("strb_rdata", rd_d, 32'h1122_CC44);
    @(negedge clk_sys);
    vid_addr = 10'd5;
    @(posedge clk_sys);
    #1;
    check_val("vid_word5", vid_data, 32'h1122_CC44);
    vid_addr = 10'd2;
    @(posedge clk_sys);
    #1;
    check_val("vid_word2", vid_data, 32'd3);

    // BREADY stalled with a second AW pending
    @(negedge clk_sys);
    bus.S_AXI_AWADDR = 12'h01C;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h0000_0077;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_AWADDR = 12'h020;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_sys);
      check_val("stall_bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd1);
      check_val("stall_bresp",   {30'd0, bus.S_AXI_BRESP},   32'd0);
      check_val("stall_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
      check_val("stall_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    end
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    ok_cnt++;
    check_val("stall_aw_free", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
    @(posedge clk_sys);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    check_val("stall_aw_taken", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    bus.S_AXI_WDATA = 32'h0000_0088;
    bus.S_AXI_WVALID = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_WVALID = 1'b0;
    check_val("stall2_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    ok_cnt++;
    axi_read(12'h01C, rd_d, rd_r);
    check_val("stall_rd1", rd_d, 32'h0000_0077);
    axi_read(12'h020, rd_d, rd_r);
    check_val("stall_rd2", rd_d, 32'h0000_0088);

    // range boundaries
    axi_write(12'h964, 32'hDEAD_BEEF, 4'hF, wr_r);
    check_val("oor601_bresp", {30'd0, wr_r}, 32'd2);
    axi_read(12'h964, rd_d, rd_r);
`ifdef TEXT_VRAM_WRCOUNT_EN
    check_val("cnt_rdata", rd_d, 32'(ok_cnt));
    check_val("cnt_rresp", {30'd0, rd_r}, 32'd0);
`else
    check_val("oor601_rdata", rd_d, 32'd0);
    check_val("oor601_rresp", {30'd0, rd_r}, 32'd2);
`endif
    axi_write(12'hFFC, 32'h1234_5678, 4'hF, wr_r);
    check_val("oor1023_bresp", {30'd0, wr_r}, 32'd2);
    axi_read(12'hFFC, rd_d, rd_r);
    check_val("oor1023_rdata", rd_d, 32'd0);
    check_val("oor1023_rresp", {30'd0, rd_r}, 32'd2);
    axi_write(12'h960, 32'h0000_C0DE, 4'hF, wr_r);
    ok_cnt++;
    check_val("ctrl_bresp", {30'd0, wr_r}, 32'd0);
    axi_read(12'h960, rd_d, rd_r);
    check_val("ctrl_rdata", rd_d, 32'h0000_C0DE);
    check_val("ctrl_rresp", {30'd0, rd_r}, 32'd0);
`ifdef TEXT_VRAM_WRCOUNT_EN
    axi_read(12'h964, rd_d, rd_r);
    check_val("cnt_rdata2", rd_d, 32'(ok_cnt));
`endif

    // read, video and write commit all on word 1 in the same edge
    @(negedge clk_sys);
    bus.S_AXI_AWADDR = 12'h004;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h0000_0055;
    bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 12'h004;
    bus.S_AXI_ARVALID = 1'b1;
    vid_addr = 10'd1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_ARVALID = 1'b0;
    check_val("coll_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
    check_val("coll_rdata", bus.S_AXI_RDATA, 32'd2);
    check_val("coll_vid_old", vid_data, 32'd2);
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    ok_cnt++;
    check_val("coll_vid_new", vid_data, 32'h0000_0055);
    axi_read(12'h004, rd_d, rd_r);
    check_val("coll_rd_new", rd_d, 32'h0000_0055);

    // asynchronous reset while RVALID is high
    @(negedge clk_sys);
    bus.S_AXI_ARADDR = 12'h000;
    bus.S_AXI_ARVALID = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.S_AXI_ARVALID = 1'b0;
    check_val("pre_rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd0);
    check_val("async_rst_rdata", bus.S_AXI_RDATA, 32'd0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    #1;
    check_val("rel_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    check_val("rel_wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
    check_val("rel_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    axi_read(12'h000, rd_d, rd_r);
    check_val("rst_word0", rd_d, 32'd0);
    check_val("rst_word0_rresp", {30'd0, rd_r}, 32'd0);
`ifdef TEXT_VRAM_WRCOUNT_EN
    axi_read(12'h964, rd_d, rd_r);
    check_val("rst_cnt", rd_d, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
